// File: rtl/hs_rx_arbiter.sv
// Round-robin arbiter that funnels N four-phase req/ack senders onto one receiver
// handshake channel, with an ack timeout so a dead receiver cannot hang the channel.
module hs_rx_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 6,
  parameter int unsigned TO_CYC = 16
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    req_in,
  input  logic [N*DW-1:0] data_in,
  output logic [N-1:0]    ack_out,
  output logic [N-1:0]    grant,
  output logic            rx_req,
  output logic [DW-1:0]   rx_data,
  input  logic            rx_ack,
  output logic            err,
  output logic            busy,
  output logic [7:0]      xfer_cnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TO_CYC - 1);
  localparam logic [PW-1:0] PtrLast = PW'(N - 1);
  localparam logic [N-1:0]  OneHot0 = N'(1);

  typedef enum logic [2:0] {StIdle, StReq, StAck, StRel, StErr} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           rx_req_q, rx_req_d;
  logic [DW-1:0]  rx_data_q, rx_data_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic [7:0]     xfer_q, xfer_d;

  logic           found;
  logic [PW-1:0]  win;
  logic [PW-1:0]  idx;
  logic [DW-1:0]  win_data;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_q) + i) % N);
      if (!found && req_in[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win == PW'(k)) begin
        win_data = data_in[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    grant_d   = grant_q;
    ack_d     = '0;
    rx_req_d  = 1'b0;
    rx_data_d = rx_data_q;
    err_d     = 1'b0;
    xfer_d    = xfer_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StReq;
          sel_d     = win;
          grant_d   = OneHot0 << win;
          rx_data_d = win_data;
          cnt_d     = '0;
          abort_d   = 1'b0;
          rx_req_d  = 1'b1;
        end
      end
      StReq: begin
        rx_req_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // An ack arriving in the last allowed cycle still wins over the abort.
        if (rx_ack) begin
          state_d = StAck;
          ack_d   = OneHot0 << sel_q;
        end else if (cnt_q == CntLast) begin
          state_d  = StErr;
          err_d    = 1'b1;
          abort_d  = 1'b1;
          rx_req_d = 1'b0;
        end
      end
      StAck: begin
        if (req_in[sel_q]) begin
          ack_d    = OneHot0 << sel_q;
          rx_req_d = 1'b1;
        end else begin
          state_d = StRel;
        end
      end
      StErr: begin
        state_d = StRel;
      end
      StRel: begin
        if (!rx_ack) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (sel_q == PtrLast) ? '0 : sel_q + 1'b1;
          if (!abort_q) begin
            xfer_d = xfer_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      rx_req_q  <= 1'b0;
      rx_data_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      xfer_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      rx_req_q  <= rx_req_d;
      rx_data_q <= rx_data_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      xfer_q    <= xfer_d;
    end
  end

  assign ack_out  = ack_q;
  assign grant    = grant_q;
  assign rx_req   = rx_req_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign xfer_cnt = xfer_q;

endmodule
